// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the two-requester RAM port arbiter: operation encoding
// and requester index type.
package ram_port_arbiter_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } ram_op_t;

    localparam int NUM_REQ   = 2;
    localparam int REQ_IDX_W = 1;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    function automatic req_idx_t other_req(input req_idx_t idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. The pointer names the requester that wins a
// tie and moves past whoever was granted.
module rr_arbiter2
    import ram_port_arbiter_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     elig_i,
    output logic [1:0]     gnt_o,
    output logic           gnt_valid_o,
    output req_idx_t       gnt_idx_o
);

    req_idx_t ptr_q;
    req_idx_t ptr_d;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = ptr_q;
        case (elig_i)
            2'b01: begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = 1'b0;
            end
            2'b10: begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = 1'b1;
            end
            2'b11: begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = ptr_q;
            end
            default: begin
                gnt_valid_o = 1'b0;
            end
        endcase
        gnt_o = gnt_valid_o ? (2'b01 << gnt_idx_o) : 2'b00;
        ptr_d = gnt_valid_o ? other_req(gnt_idx_o) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the RAM's single read/write port pair between two requesters,
// stalling a read that would race the one-cycle-delayed write commit.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH:0]   req0_addr,
    input  logic [WIDTH-1:0]      req0_wdata,
    output logic                  resp0_valid,
    output logic [WIDTH-1:0]      resp0_data,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH:0]   req1_addr,
    input  logic [WIDTH-1:0]      req1_wdata,
    output logic                  resp1_valid,
    output logic [WIDTH-1:0]      resp1_data,

    output logic                  ram_wen,
    output logic [ADDR_WIDTH:0]   ram_waddr,
    output logic [WIDTH-1:0]      ram_wdata,
    output logic [ADDR_WIDTH:0]   ram_raddr,
    input  logic [WIDTH-1:0]      ram_rdata
);

    ram_op_t             op0;
    ram_op_t             op1;
    logic                hazard0;
    logic                hazard1;
    logic [1:0]          elig;
    logic [1:0]          gnt;
    logic                gnt_valid;
    req_idx_t            gnt_idx;

    ram_op_t             gnt_op;
    logic [ADDR_WIDTH:0] gnt_addr;
    logic [WIDTH-1:0]    gnt_wdata;
    logic                wr_gnt;
    logic                rd_gnt;

    logic                wr_pend_q,      wr_pend_d;
    logic [ADDR_WIDTH:0] wr_pend_addr_q, wr_pend_addr_d;
    logic                rd_inflight_q,  rd_inflight_d;
    req_idx_t            rd_owner_q,     rd_owner_d;
    logic [ADDR_WIDTH:0] raddr_q,        raddr_d;

    assign op0 = ram_op_t'(req0_we);
    assign op1 = ram_op_t'(req1_we);

    // A read of the address written last cycle would see stale RAM contents.
    assign hazard0 = (op0 == OP_READ) && wr_pend_q && (req0_addr == wr_pend_addr_q);
    assign hazard1 = (op1 == OP_READ) && wr_pend_q && (req1_addr == wr_pend_addr_q);

    assign elig = {req1_valid & ~hazard1, req0_valid & ~hazard0};

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .elig_i      (elig),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        gnt_op    = op0;
        gnt_addr  = req0_addr;
        gnt_wdata = req0_wdata;
        if (gnt_idx == 1'b1) begin
            gnt_op    = op1;
            gnt_addr  = req1_addr;
            gnt_wdata = req1_wdata;
        end
        wr_gnt = gnt_valid && (gnt_op == OP_WRITE);
        rd_gnt = gnt_valid && (gnt_op == OP_READ);
    end

    always_comb begin
        wr_pend_d      = wr_gnt;
        wr_pend_addr_d = wr_gnt ? gnt_addr : wr_pend_addr_q;
        rd_inflight_d  = rd_gnt;
        rd_owner_d     = rd_gnt ? gnt_idx : rd_owner_q;
        raddr_d        = rd_gnt ? gnt_addr : raddr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_pend_q      <= 1'b0;
            wr_pend_addr_q <= '0;
            rd_inflight_q  <= 1'b0;
            rd_owner_q     <= '0;
            raddr_q        <= '0;
        end else begin
            wr_pend_q      <= wr_pend_d;
            wr_pend_addr_q <= wr_pend_addr_d;
            rd_inflight_q  <= rd_inflight_d;
            rd_owner_q     <= rd_owner_d;
            raddr_q        <= raddr_d;
        end
    end

    // Grant-derived outputs are combinational, so force them low during reset.
    always_comb begin
        req0_ready  = rst & gnt[0];
        req1_ready  = rst & gnt[1];
        ram_wen     = rst & wr_gnt;
        ram_waddr   = ram_wen ? gnt_addr  : '0;
        ram_wdata   = ram_wen ? gnt_wdata : '0;
        ram_raddr   = rst ? raddr_d : '0;
        resp0_valid = rst & rd_inflight_q & (rd_owner_q == 1'b0);
        resp1_valid = rst & rd_inflight_q & (rd_owner_q == 1'b1);
        resp0_data  = resp0_valid ? ram_rdata : '0;
        resp1_data  = resp1_valid ? ram_rdata : '0;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares the single read/write port pair of the on-chip RAM between two requesters (e.g. two HLS-generated datapaths).
- Issues at most one operation per cycle to the RAM and returns read data to the correct requester.
- Enforces the RAM's write timing: a write commits one cycle after issue, so a read to the same address issued in the next cycle is stalled one cycle.

Parameters:
- WIDTH, 32, data word width; must match the RAM instance.
- DEPTH, 16, RAM depth in words.
- ADDR_WIDTH, $clog2(DEPTH), address ports are ADDR_WIDTH+1 bits wide, matching the RAM port convention.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_WIDTH+1  word address.
- req0_wdata  in  WIDTH  write data.
- resp0_valid  out  1  read data for requester 0 valid; no backpressure.
- resp0_data  out  WIDTH  read data.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, resp1_valid, resp1_data: identical to requester 0.
- ram_wen  out  1  to RAM wen_0.
- ram_waddr  out  ADDR_WIDTH+1  to RAM waddr_0.
- ram_wdata  out  WIDTH  to RAM wdata_0.
- ram_raddr  out  ADDR_WIDTH+1  to RAM raddr_0.
- ram_rdata  in  WIDTH  from RAM rdata_0; valid one cycle after ram_raddr is presented.

Behaviour:
- Reset (rst=0, async): rr_ptr=0 (requester 0 has priority), wr_pend=0, rd_inflight=0. All outputs are 0 while rst=0: ready, resp_valid, ram_wen, addresses, wdata.
- Eligibility: requester i is eligible when reqi_valid=1 and it is not hazard-blocked.
- Hazard block: reqi is a read, wr_pend=1, and reqi_addr==wr_pend_addr. wr_pend/wr_pend_addr record a write granted in the previous cycle.
- Grant:
  - At most one grant per cycle, combinational from the current inputs and state.
  - If both requesters are eligible, grant the one indicated by rr_ptr.
  - If exactly one is eligible, grant it.
  - reqi_ready=1 only in the cycle requester i is granted; the transfer occurs when valid and ready are both 1.
- rr_ptr update: on any grant, rr_ptr <= the other requester index. With no grant, rr_ptr is held.
- Write grant:
  - Same cycle: ram_wen=1, ram_waddr=addr, ram_wdata=wdata.
  - Next edge: wr_pend<=1, wr_pend_addr<=addr.
  - No response is generated for writes.
- Read grant:
  - Same cycle: ram_raddr=addr, ram_wen=0.
  - Next edge: rd_inflight<=1, rd_owner<=i.
  - Next cycle: respi_valid=1 with respi_data=ram_rdata for the owner. The other requester's resp_valid stays 0.
- Idle cycles: ram_wen=0 and ram_raddr holds its last value. Any cycle without a write grant clears wr_pend at the next edge.
- Read latency is exactly 1 cycle from handshake to resp_valid. Write visibility: a read of the same address is granted no earlier than 2 cycles after the write handshake.
- Hazard-blocked requester: the other requester may be granted in that cycle. If the other requester is granted a write, wr_pend is refreshed with the new write's address.
- Back-to-back: one operation per cycle sustained; reads and writes may alternate freely apart from the hazard stall.
- Same-address write followed by write: no stall, since writes commit in order.
- Reset mid-operation:
  - An in-flight read response is dropped; resp_valid=0 after reset.
  - A pending write is not cancelled at the RAM, which owns its own delay stage.
  - The arbiter forgets wr_pend.
- Address width: addresses are compared over the full ADDR_WIDTH+1 bits, with no truncation.

Decomposition:
- Shared package: ram_op_t (READ=0, WRITE=1) and requester index width (1 bit for 2 requesters).
- One natural sub-module: rr_arbiter2, a 2-input round-robin grant with pointer register. The hazard check and response steering stay in the top module.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, then release with both valid=0. Required: all readies, resp_valids and ram_wen stay 0.
2. Single write then read, same address: req0 writes addr 5 / data 0xDEADBEEF at cycle t, then reads addr 5 at t+1. Required: req0_ready=0 at t+1 (stall); read granted at t+2; resp0_valid=1 with 0xDEADBEEF at t+3.
3. Contention: both read every cycle, addrs 1 and 2, after reset. Required: grants alternate 0,1,0,1. resp0/resp1 alternate one cycle later with RAM contents at addrs 1 and 2; never both valid.
4. Hazard bypass: req1 writes addr 3 at t. At t+1, req0 reads addr 3 and req1 reads addr 4. Required: req1 granted at t+1; req0 granted at t+2 and receives the new addr-3 data.
5. Write-write same address: req0 writes addr 7=0x1 then addr 7=0x2 on consecutive cycles, then reads addr 7. Required: no stall on the second write; read returns 0x2.
6. Mid-read reset: read granted at t, rst asserted low between t and t+1. Required: resp_valid=0 at t+1; rr_ptr=0 after release.
